// File: rtl/mk_keybank_if.sv
// Command / write-word / read-word / response handshake bundle for mk_keybank.
// The L3 command decoder is the master and the key bank is the slave.
interface mk_keybank_if #(
  parameter int DW = 32
);
  logic          cmd_en;
  logic [3:0]    cmd_op;
  logic [3:0]    cmd_id;
  logic          cmd_rdy;
  logic [DW-1:0] wd;
  logic          wd_vld;
  logic          wd_rdy;
  logic [DW-1:0] rd;
  logic          rd_vld;
  logic          rd_rdy;
  logic [7:0]    resp;
  logic          resp_vld;
  logic          resp_rdy;

  modport master (
    output cmd_en, cmd_op, cmd_id, wd, wd_vld, rd_rdy, resp_rdy,
    input  cmd_rdy, wd_rdy, rd, rd_vld, resp, resp_vld
  );

  modport slave (
    input  cmd_en, cmd_op, cmd_id, wd, wd_vld, rd_rdy, resp_rdy,
    output cmd_rdy, wd_rdy, rd, rd_vld, resp, resp_vld
  );
endinterface

// File: rtl/mk_keybank.sv
// Multi-session key bank: binds L3 session IDs to key slots and serves K/PSK of cur_id.
// Optional PSK readback is enabled by defining MK_KEYBANK_RDBACK_EN.
module mk_keybank #(
  parameter int NSLOT = 8,
  parameter int KEY_W = 256,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_mk,
  mk_keybank_if.slave      bus,
  input  logic [KEY_W-1:0] ecdh_sk,
  input  logic             ecdh_sk_update,
  input  logic [3:0]       cur_id,
  output logic [KEY_W-1:0] k,
  output logic [KEY_W-1:0] psk,
  output logic             key_vld
);
  localparam int WPK  = KEY_W / DW;
  localparam int SW   = $clog2(NSLOT);
  localparam int CMAX = (WPK > NSLOT) ? WPK : NSLOT;
  localparam int CW   = $clog2(CMAX);

  localparam logic [3:0] OP_OPEN    = 4'd0;
  localparam logic [3:0] OP_CLOSE   = 4'd1;
  localparam logic [3:0] OP_WR_K    = 4'd2;
  localparam logic [3:0] OP_WR_PSK  = 4'd3;
  localparam logic [3:0] OP_RD_PSK  = 4'd4;
  localparam logic [3:0] OP_LOAD_SK = 4'd5;

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_RESP, ST_ZERO} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             wr_k_q, wr_k_d;
  logic [7:0]       resp_q, resp_d;
  logic [NSLOT-1:0] bound_q, bound_d;
  logic [NSLOT-1:0] kset_q, kset_d;
  logic [3:0]       id_q [NSLOT];
  logic [3:0]       id_d [NSLOT];
  logic [KEY_W-1:0] sk_q [NSLOT];
  logic [KEY_W-1:0] sk_d [NSLOT];
  logic [KEY_W-1:0] pk_q [NSLOT];
  logic [KEY_W-1:0] pk_d [NSLOT];
  logic [KEY_W-1:0] stg_q, stg_d;
  logic             stg_vld_q, stg_vld_d;

  logic             hit_s, free_s, stg_take_s;
  logic [SW-1:0]    hit_idx_s, free_idx_s, zidx_s;
  logic [NSLOT-1:0] match_s;
  int               widx_s;

  assign widx_s     = int'(cnt_q) * DW;
  assign zidx_s     = SW'(cnt_q);
  assign stg_take_s = ecdh_sk_update && (state_q != ST_ZERO);

  // Slot search: slot holding cmd_id, and the lowest-index free slot.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      hit_s      = hit_s | (bound_q[i] && (id_q[i] == bus.cmd_id));
      hit_idx_s  = (bound_q[i] && (id_q[i] == bus.cmd_id)) ? SW'(i) : hit_idx_s;
      free_s     = free_s | !bound_q[i];
      free_idx_s = !bound_q[i] ? SW'(i) : free_idx_s;
    end
  end

  // Next-state and slot-update logic of the command FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    wr_k_d    = wr_k_q;
    resp_d    = resp_q;
    bound_d   = bound_q;
    kset_d    = kset_q;
    id_d      = id_q;
    sk_d      = sk_q;
    pk_d      = pk_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    if (clr_mk && (state_q != ST_ZERO)) begin
      state_d = ST_ZERO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_en) begin
            state_d = ST_RESP;
            resp_d  = 8'h00;
            case (bus.cmd_op)
              OP_OPEN: begin
                if (hit_s) begin
                  resp_d = 8'h01;
                end else if (!free_s) begin
                  resp_d = 8'h06;
                end else begin
                  bound_d[free_idx_s] = 1'b1;
                  kset_d[free_idx_s]  = 1'b0;
                  id_d[free_idx_s]    = bus.cmd_id;
                end
              end
              OP_CLOSE, OP_WR_K, OP_WR_PSK, OP_RD_PSK, OP_LOAD_SK: begin
                if (!hit_s) begin
                  resp_d = 8'h03;
                end else begin
                  sel_d  = hit_idx_s;
                  cnt_d  = '0;
                  wr_k_d = (bus.cmd_op == OP_WR_K);
                  case (bus.cmd_op)
                    OP_CLOSE: begin
                      bound_d[hit_idx_s] = 1'b0;
                      kset_d[hit_idx_s]  = 1'b0;
                      id_d[hit_idx_s]    = 4'h0;
                      sk_d[hit_idx_s]    = '0;
                      pk_d[hit_idx_s]    = '0;
                    end
                    OP_WR_K, OP_WR_PSK: state_d = ST_WR;
                    OP_RD_PSK: begin
`ifdef MK_KEYBANK_RDBACK_EN
                      state_d = ST_RD;
`else
                      resp_d = 8'h04;
`endif
                    end
                    OP_LOAD_SK: begin
                      if (stg_vld_q) begin
                        sk_d[hit_idx_s]   = stg_q;
                        kset_d[hit_idx_s] = 1'b1;
                        stg_d             = '0;
                        stg_vld_d         = 1'b0;
                      end else begin
                        resp_d = 8'h05;
                      end
                    end
                    default: resp_d = 8'h02;
                  endcase
                end
              end
              default: resp_d = 8'h02;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR: begin
          if (bus.wd_vld) begin
            if (wr_k_q) begin
              sk_d[sel_q][widx_s +: DW] = bus.wd;
            end else begin
              pk_d[sel_q][widx_s +: DW] = bus.wd;
            end
            if (cnt_q == CW'(WPK - 1)) begin
              kset_d[sel_q] = kset_q[sel_q] | wr_k_q;
              resp_d        = 8'h00;
              state_d       = ST_RESP;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RD: begin
          if (bus.rd_rdy) begin
            if (cnt_q == CW'(WPK - 1)) begin
              resp_d  = 8'h00;
              state_d = ST_RESP;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RESP: begin
          if (bus.resp_rdy) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
        ST_ZERO: begin
          bound_d[zidx_s] = 1'b0;
          kset_d[zidx_s]  = 1'b0;
          id_d[zidx_s]    = 4'h0;
          sk_d[zidx_s]    = '0;
          pk_d[zidx_s]    = '0;
          if (cnt_q == CW'(0)) begin
            stg_d     = '0;
            stg_vld_d = 1'b0;
          end else begin
            stg_vld_d = stg_vld_q;
          end
          // A still-asserted clr_mk at the last sweep cycle restarts the sweep.
          if (cnt_q == CW'(NSLOT - 1)) begin
            cnt_d   = '0;
            state_d = clr_mk ? ST_ZERO : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    stg_d     = stg_take_s ? ecdh_sk : stg_d;
    stg_vld_d = stg_take_s ? 1'b1 : stg_vld_d;
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      wr_k_q    <= 1'b0;
      resp_q    <= 8'h00;
      bound_q   <= '0;
      kset_q    <= '0;
      stg_q     <= '0;
      stg_vld_q <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        id_q[i] <= 4'h0;
        sk_q[i] <= '0;
        pk_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      wr_k_q    <= wr_k_d;
      resp_q    <= resp_d;
      bound_q   <= bound_d;
      kset_q    <= kset_d;
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      for (int i = 0; i < NSLOT; i++) begin
        id_q[i] <= id_d[i];
        sk_q[i] <= sk_d[i];
        pk_q[i] <= pk_d[i];
      end
    end
  end

  // Lookup of the slot bound to cur_id; blanked during the zeroize sweep.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NSLOT; i++) begin
      match_s[i] = bound_q[i] && (id_q[i] == cur_id) && (state_q != ST_ZERO);
    end
  end

  // At most one slot can match, so an OR-reduction acts as the mux.
  always_comb begin
    k       = '0;
    psk     = '0;
    key_vld = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      k       = k   | ({KEY_W{match_s[i]}} & sk_q[i]);
      psk     = psk | ({KEY_W{match_s[i]}} & pk_q[i]);
      key_vld = key_vld | (match_s[i] & kset_q[i]);
    end
  end

  assign bus.cmd_rdy  = (state_q == ST_IDLE);
  assign bus.wd_rdy   = (state_q == ST_WR);
  assign bus.resp_vld = (state_q == ST_RESP);
  assign bus.resp     = resp_q;

`ifdef MK_KEYBANK_RDBACK_EN
  assign bus.rd_vld = (state_q == ST_RD);
  assign bus.rd     = (state_q == ST_RD) ? pk_q[sel_q][widx_s +: DW] : '0;
`else
  assign bus.rd_vld = 1'b0;
  assign bus.rd     = '0;
`endif

endmodule
